// File: rtl/mii_tx_framer_pkg.sv
// Shared constants and state encoding for the MII transmit framer.
// MII_TX_PAD_EN adds the PAD state used for minimum-length zero padding.
package mii_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PREAMBLE,
    SFD,
    DATA,
`ifdef MII_TX_PAD_EN
    PAD,
`endif
    FCS,
    ERR,
    IFG
  } state_t;

  localparam int          PREAMBLE_BYTES = 7;
  localparam logic [7:0]  SFD_BYTE       = 8'hD5;
  localparam int          MIN_PAYLOAD    = 60;
  localparam int          IFG_CYCLES     = 24;
  localparam logic [31:0] CRC_POLY       = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT       = 32'hFFFFFFFF;

endpackage

// File: rtl/mii_tx_framer_crc32_d8.sv
// Byte-wide reflected CRC-32 next-state function (combinational only).
module crc32_d8
  import mii_tx_pkg::*;
(
  input  logic [31:0] crc,
  input  logic [7:0]  data,
  output logic [31:0] crc_next
);

  logic [31:0] c;

  always_comb begin
    c = crc ^ {24'd0, data};
    for (int i = 0; i < 8; i++)
      c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
    crc_next = c;
  end

endmodule

// File: rtl/mii_tx_framer.sv
// MII TX framer: preamble, SFD, payload, optional zero pad, FCS and IFG on 4-bit TXD.
// Build with MII_TX_PAD_EN defined to pad short payloads to MIN_PAYLOAD bytes.
module mii_tx_framer
  import mii_tx_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] s_data,
  input  logic       s_valid,
  input  logic       s_last,
  output logic       s_ready,
  output logic [3:0] txd,
  output logic       tx_en,
  output logic       tx_er,
  output logic       busy,
  output logic       underrun
);

  state_t      state, state_n;
  logic [4:0]  cyc, cyc_n;
  logic [7:0]  byte_q, byte_n;
  logic        last_q, last_n;
  logic [10:0] cnt, cnt_n, cnt_inc;
  logic [31:0] crc, crc_n, crc_upd, fcs;
  logic        ph, ur;
  logic [3:0]  txd_n;
  logic        en_n, er_n, rdy_n;

  crc32_d8 u_crc (.crc(crc), .data(byte_q), .crc_next(crc_upd));

  assign ph      = cyc[0];
  assign ur      = s_ready && !s_valid;
  assign cnt_inc = (cnt == 11'h7FF) ? cnt : cnt + 11'd1;

  always_comb begin
    state_n = state;
    cyc_n   = cyc + 5'd1;
    byte_n  = byte_q;
    last_n  = last_q;
    cnt_n   = cnt;
    crc_n   = crc;
    case (state)
      IDLE: begin
        cyc_n = '0;
        if (s_valid) state_n = PREAMBLE;
      end
      PREAMBLE:
        if (cyc == 5'(2*PREAMBLE_BYTES-1)) begin
          state_n = SFD;
          cyc_n   = '0;
        end
      SFD:
        if (ph) begin
          cyc_n = '0;
          if (ur) state_n = ERR;
          else begin
            state_n = DATA;
            byte_n  = s_data;
            last_n  = s_last;
            cnt_n   = '0;
            crc_n   = CRC_INIT;
          end
        end
      DATA:
        if (ph) begin
          crc_n = crc_upd;
          cnt_n = cnt_inc;
          cyc_n = '0;
          if (last_q) begin
            state_n = FCS;
`ifdef MII_TX_PAD_EN
            if (cnt_inc < 11'(MIN_PAYLOAD)) begin
              state_n = PAD;
              byte_n  = '0;
            end
`endif
          end else if (ur) state_n = ERR;
          else begin
            byte_n = s_data;
            last_n = s_last;
          end
        end
`ifdef MII_TX_PAD_EN
      PAD:
        if (ph) begin
          crc_n = crc_upd;
          cnt_n = cnt_inc;
          cyc_n = '0;
          if (cnt_inc >= 11'(MIN_PAYLOAD)) state_n = FCS;
        end
`endif
      FCS:
        if (cyc == 5'd7) begin
          state_n = IFG;
          cyc_n   = '0;
        end
      ERR: begin
        state_n = IFG;
        cyc_n   = '0;
      end
      IFG:
        // the final gap cycle doubles as IDLE so back-to-back frames keep an exact gap
        if (cyc == 5'(IFG_CYCLES-1)) begin
          state_n = s_valid ? PREAMBLE : IDLE;
          cyc_n   = '0;
        end
      default: begin
        state_n = IDLE;
        cyc_n   = '0;
      end
    endcase
  end

  // outputs are registered, so they are decoded from the state being entered
  always_comb begin
    fcs   = ~crc_n;
    txd_n = '0;
    en_n  = 1'b1;
    er_n  = 1'b0;
    rdy_n = 1'b0;
    case (state_n)
      PREAMBLE: txd_n = 4'h5;
      SFD: begin
        txd_n = cyc_n[0] ? SFD_BYTE[7:4] : SFD_BYTE[3:0];
        rdy_n = cyc_n[0];
      end
      DATA: begin
        txd_n = cyc_n[0] ? byte_n[7:4] : byte_n[3:0];
        rdy_n = cyc_n[0] && !last_n;
      end
`ifdef MII_TX_PAD_EN
      PAD: txd_n = 4'h0;
`endif
      FCS: txd_n = fcs[{cyc_n[2:0], 2'b00} +: 4];
      ERR: er_n = 1'b1;
      default: en_n = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cyc      <= '0;
      byte_q   <= '0;
      last_q   <= 1'b0;
      cnt      <= '0;
      crc      <= CRC_INIT;
      txd      <= '0;
      tx_en    <= 1'b0;
      tx_er    <= 1'b0;
      s_ready  <= 1'b0;
      busy     <= 1'b0;
      underrun <= 1'b0;
    end else begin
      state    <= state_n;
      cyc      <= cyc_n;
      byte_q   <= byte_n;
      last_q   <= last_n;
      cnt      <= cnt_n;
      crc      <= crc_n;
      txd      <= txd_n;
      tx_en    <= en_n;
      tx_er    <= er_n;
      s_ready  <= rdy_n;
      busy     <= (state_n != IDLE);
      underrun <= (state_n == ERR);
    end
  end

endmodule

// File: doc/mii_tx_framer.md
# mii_tx_framer

Fabric-side Ethernet MII transmitter for the EBAZ board: takes a byte stream with a valid/ready/last handshake and emits a complete 802.3 frame on the 4-bit MII TX pins. The frame includes preamble, SFD, optional minimum-length padding, CRC-32 FCS and inter-frame gap. It is the transmit end of the same MII link the PS7 GEM otherwise drives over EMIO, so fabric logic can source frames to the PHY directly. It runs in the PHY TX clock domain, which is the 25 MHz clock shared with CLK25.

## Interface
- No parameters; all lengths are fixed constants in the shared package.
- clk  input  1  MII TX clock, 25 MHz (100 Mb/s); all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- s_data  input  8  payload byte, destination MAC first.
- s_valid  input  1  s_data valid; in IDLE also requests frame start.
- s_last  input  1  current byte is the final payload byte.
- s_ready  output  1  byte accepted this cycle when s_valid && s_ready.
- txd  output  4  MII TXD[3:0].
- tx_en  output  1  MII TX_EN.
- tx_er  output  1  MII TX_ER.
- busy  output  1  high in every state except IDLE.
- underrun  output  1  one-cycle pulse on payload underrun.

## Operation
- Reset values: txd=0, tx_en=0, tx_er=0, s_ready=0, busy=0, underrun=0, state=IDLE. All outputs are registered.
- States and transitions: IDLE → PREAMBLE → SFD → DATA → (PAD) → FCS → IFG → IDLE.
- Each byte occupies two cycles. Low nibble goes out first (phase 0), then the high nibble (phase 1).
- IDLE: tx_en=0, txd=0. When s_valid=1, the block enters PREAMBLE. No byte is consumed in IDLE.
- PREAMBLE: 7 bytes of 0x55, 14 cycles of txd=5.
- SFD: byte 0xD5, txd=5 then D. s_ready=1 on phase 1; the first payload byte is captured here.
- DATA: sends the captured byte. s_ready=1 on every phase-1 cycle.
  - Accepting a byte with s_last=1 ends payload intake. After that byte, the block enters PAD if count<60 (macro enabled), otherwise FCS.
  - s_ready=0 after s_last has been accepted.
- Underrun: s_valid=0 while s_ready=1.
  - Next nibble goes out with tx_er=1, tx_en=1, txd=0.
  - underrun pulses for one cycle.
  - Block skips FCS and goes straight to IFG. A frame already in progress is never restarted.
- PAD: sends 0x00 bytes until the payload byte count reaches 60.
- CRC-32 (IEEE):
  - Reflected polynomial 0xEDB88320, init 0xFFFFFFFF.
  - Updated once per payload or pad byte, on phase 1.
  - FCS is the inverted CRC, sent LSB byte first, low nibble first (8 cycles).
- IFG: tx_en=0 for 24 cycles (12 byte times). s_valid is ignored.
- Byte counter is 11 bits and saturates at 2047. It is used only for the pad decision; there is no maximum-length enforcement.
- Async reset mid-frame: tx_en drops on reset assertion with no FCS. After release the block starts in IDLE and enforces no IFG.

## Timing
- s_valid rising in IDLE at cycle N → first preamble nibble with tx_en=1 at cycle N+1.
- First s_ready pulse is at cycle N+16 (SFD phase 1).
- That byte's low nibble is on txd at N+17.
- s_ready pulses every 2 cycles during DATA. Maximum sustained rate is 1 byte per 2 clk.
- Frame with L payload bytes (L≥60 or macro off): tx_en is high for 16+2L+8 cycles, followed by 24 low cycles.
- Back-to-back frames: the earliest next tx_en comes 24 cycles after the last FCS nibble.

## Configuration
- MII_TX_PAD_EN defined: frames shorter than 60 payload bytes are zero-padded to 60, and the CRC covers the padding. This gives a 64-byte minimum frame.
- MII_TX_PAD_EN undefined: PAD state is absent and the FCS follows the last payload byte immediately. Short frames are the user's responsibility.

## Structure
- Package mii_tx_pkg holds:
  - state enum.
  - PREAMBLE_BYTES=7, SFD_BYTE=8'hD5, MIN_PAYLOAD=60, IFG_CYCLES=24.
  - CRC_POLY=32'hEDB88320, CRC_INIT=32'hFFFFFFFF.
- One sub-module, crc32_d8: combinational byte-wide next-CRC function, instantiated once. The CRC register lives in the parent.

## Test plan
- Reset: hold rst → all outputs 0. Release and leave s_valid=0 for 100 cycles → tx_en stays 0.
- Macro off, payload ASCII "123456789": 14×txd=5, then 5,D, data nibbles, then FCS nibbles 6,2,9,3,4,F,B,C. tx_en is high for 16+18+8=42 cycles.
- Macro on, 1-byte payload 0xAB: 59 zero pad bytes follow. The FCS matches a software CRC of the 60 bytes. tx_en is high for 16+120+8=144 cycles.
- Underrun: 100-byte frame with s_valid dropped at byte 10 → one nibble with tx_er=1, one underrun pulse, no FCS, 24-cycle IFG, then return to IDLE.
- Back-to-back: two 64-byte frames with s_valid held high → exactly 24 tx_en-low cycles between them, and s_ready never asserted in IFG.
- Reset mid-DATA: assert rst at byte 30 → tx_en drops immediately. The next frame after release starts with a full preamble.
